// File: rtl/cache_bus_pkg.sv
// Shared types and constants for the common-bus arbitration logic.
// Requester index = 2*core + {0: DL, 1: IL}.
package cache_bus_pkg;

  localparam int CORES   = 4;
  localparam int NUM_REQ = 2 * CORES;
  localparam int IDX_W   = $clog2(NUM_REQ);

  typedef logic [IDX_W-1:0] owner_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  function automatic owner_idx_t cache_idx(input int core, input logic is_il);
    return owner_idx_t'(2 * core) | owner_idx_t'(is_il);
  endfunction

endpackage

// File: rtl/com_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
// Relies on N being a power of two so the W-bit index wraps on its own.
module rr_pick #(
  parameter int N = cache_bus_pkg::NUM_REQ,
  parameter int W = cache_bus_pkg::IDX_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         valid
);

  logic [W-1:0] k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    k     = '0;
    for (int i = 1; i <= N; i++) begin
      k = ptr + W'(i);
      if (!valid && req[k]) begin
        valid  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter: round-robin processor ownership with a fixed-priority
// snoop/memory data-drive grant nested inside each tenure.
module com_bus_arbiter #(
  parameter int NUM_REQ  = cache_bus_pkg::NUM_REQ,
  parameter int MAX_HOLD = 1023,
  parameter int CNT_W    = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             Com_Bus_Req_proc,
  input  logic [NUM_REQ-1:0]             Com_Bus_Req_snoop,
  input  logic                           Mem_snoop_req,
  output logic [NUM_REQ-1:0]             Com_Bus_Gnt_proc,
  output logic [NUM_REQ-1:0]             Com_Bus_Gnt_snoop,
  output logic                           Mem_snoop_gnt,
  output logic [cache_bus_pkg::IDX_W-1:0] Bus_owner,
  output logic                           Bus_busy,
  output logic                           Bus_timeout
);
  import cache_bus_pkg::*;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_PRE = CNT_W'(MAX_HOLD - 1);

  arb_state_e         state;
  owner_idx_t         rr_ptr;
  logic [CNT_W-1:0]   hold_cnt;

  logic [NUM_REQ-1:0] pick_gnt;
  owner_idx_t         pick_idx;
  logic               pick_valid;

  logic [NUM_REQ-1:0] snoop_cand;
  logic [NUM_REQ-1:0] snoop_onehot;
  logic               snoop_any;
  logic               snoop_active;
  logic               snoop_keep;

  rr_pick #(
    .N (NUM_REQ),
    .W (IDX_W)
  ) u_rr_pick (
    .req   (Com_Bus_Req_proc),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // The owner never responds to its own transaction; lowest index wins.
  always_comb begin
    snoop_cand            = Com_Bus_Req_snoop;
    snoop_cand[Bus_owner] = 1'b0;
    snoop_onehot          = snoop_cand & (~snoop_cand + NUM_REQ'(1));
    snoop_any             = |snoop_cand;
    snoop_active          = (|Com_Bus_Gnt_snoop) | Mem_snoop_gnt;
    snoop_keep            = (|(Com_Bus_Gnt_snoop & Com_Bus_Req_snoop)) |
                            (Mem_snoop_gnt & Mem_snoop_req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      rr_ptr            <= owner_idx_t'(NUM_REQ - 1);
      hold_cnt          <= '0;
      Com_Bus_Gnt_proc  <= '0;
      Com_Bus_Gnt_snoop <= '0;
      Mem_snoop_gnt     <= 1'b0;
      Bus_owner         <= '0;
      Bus_busy          <= 1'b0;
      Bus_timeout       <= 1'b0;
    end else begin
      Bus_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            Com_Bus_Gnt_proc <= pick_gnt;
            Bus_owner        <= pick_idx;
            rr_ptr           <= pick_idx;
            hold_cnt         <= '0;
            Bus_busy         <= 1'b1;
            state            <= OWN;
          end
        end
        OWN: begin
          // Release wins over any snoop activity seen in the same cycle.
          if (!Com_Bus_Req_proc[Bus_owner]) begin
            Com_Bus_Gnt_proc  <= '0;
            Com_Bus_Gnt_snoop <= '0;
            Mem_snoop_gnt     <= 1'b0;
            Bus_busy          <= 1'b0;
            state             <= TURN;
          end else begin
            if (hold_cnt != HOLD_MAX) begin
              hold_cnt <= hold_cnt + CNT_W'(1);
              if (hold_cnt == HOLD_PRE) Bus_timeout <= 1'b1;
            end
            if (snoop_active) begin
              if (!snoop_keep) begin
                Com_Bus_Gnt_snoop <= '0;
                Mem_snoop_gnt     <= 1'b0;
              end
            end else if (snoop_any) begin
              Com_Bus_Gnt_snoop <= snoop_onehot;
            end else if (Mem_snoop_req) begin
              Mem_snoop_gnt <= 1'b1;
            end
          end
        end
        TURN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_proc_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(Com_Bus_Gnt_proc));
  a_snoop_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(Com_Bus_Gnt_snoop));
  a_snoop_mem_excl: assert property (@(posedge clk) disable iff (rst)
    !((|Com_Bus_Gnt_snoop) && Mem_snoop_gnt));
  a_busy_matches: assert property (@(posedge clk) disable iff (rst)
    Bus_busy == (|Com_Bus_Gnt_proc));

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Directed test of com_bus_arbiter: stimulus pushes expected output changes,
// a negedge monitor pops and checks each observed change and its cycle.
module tb_com_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req_p;
  logic [7:0] req_s;
  logic       mem_req;
  logic [7:0] gnt_p;
  logic [7:0] gnt_s;
  logic       mem_gnt;
  logic [2:0] owner;
  logic       busy;
  logic       tmo;

  com_bus_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .Com_Bus_Req_proc  (req_p),
    .Com_Bus_Req_snoop (req_s),
    .Mem_snoop_req     (mem_req),
    .Com_Bus_Gnt_proc  (gnt_p),
    .Com_Bus_Gnt_snoop (gnt_s),
    .Mem_snoop_gnt     (mem_gnt),
    .Bus_owner         (owner),
    .Bus_busy          (busy),
    .Bus_timeout       (tmo)
  );

  typedef struct {
    string      nm;
    logic [7:0] gp;
    logic [7:0] gs;
    logic       mg;
    logic [2:0] own;
    logic       busy;
    logic       to;
    int         cyc;
  } ev_t;

  ev_t         exp_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [18:0] prev_b = '0;
  logic [18:0] cur_b;
  ev_t         e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output bundle must match the next expected event.
  always @(negedge clk) begin
    cur_b = {gnt_p, gnt_s, mem_gnt, busy, tmo};
    if (cur_b !== prev_b) begin
      prev_b = cur_b;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change cyc=%0d got gp=%h gs=%h mg=%b busy=%b to=%b",
                 cyc, gnt_p, gnt_s, mem_gnt, busy, tmo);
      end else begin
        e = exp_q.pop_front();
        if (gnt_p !== e.gp || gnt_s !== e.gs || mem_gnt !== e.mg || busy !== e.busy ||
            tmo !== e.to || cyc != e.cyc || (e.busy && owner !== e.own)) begin
          n_bad++;
          $display("FAIL %s got cyc=%0d gp=%h gs=%h mg=%b own=%0d busy=%b to=%b want cyc=%0d gp=%h gs=%h mg=%b own=%0d busy=%b to=%b",
                   e.nm, cyc, gnt_p, gnt_s, mem_gnt, owner, busy, tmo,
                   e.cyc, e.gp, e.gs, e.mg, e.own, e.busy, e.to);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string nm, input logic [7:0] gp, input logic [7:0] gs,
                      input logic mg, input logic [2:0] own, input logic b,
                      input logic to, input int dc);
    ev_t x;
    x.nm = nm; x.gp = gp; x.gs = gs; x.mg = mg; x.own = own;
    x.busy = b; x.to = to; x.cyc = cyc + dc;
    exp_q.push_back(x);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; req_p = '0; req_s = '0; mem_req = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("reset_state", {8'h0, gnt_p, gnt_s, mem_gnt, owner, busy, tmo}, 32'h0);

    // 1: single requester 0
    req_p = 8'h01;
    push("t1_grant0", 8'h01, 8'h00, 0, 3'd0, 1, 0, 1);
    tick(3);
    req_p = 8'h00;
    push("t1_release", 8'h00, 8'h00, 0, 3'd0, 0, 0, 1);
    tick(4);

    // 2: 0 and 7 alternate with two dead cycles between tenures
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    req_p = 8'h81;
    push("t2_grant0", 8'h01, 8'h00, 0, 3'd0, 1, 0, 1);
    tick(1);
    for (int k = 0; k < 4; k++) begin
      w = (k % 2 == 0) ? 0 : 7;
      tick(3);
      push("t2_release", 8'h00, 8'h00, 0, 3'd0, 0, 0, 1);
      if (k < 3) begin
        req_p = req_p & ~(8'h01 << w);
        if (w == 0) push("t2_grant7", 8'h80, 8'h00, 0, 3'd7, 1, 0, 3);
        else        push("t2_grant0", 8'h01, 8'h00, 0, 3'd0, 1, 0, 3);
      end else begin
        req_p = 8'h00;
      end
      tick(1);
      if (k < 3) req_p = 8'h81;
      tick(2);
    end
    tick(2);

    // 3: owner 2, snoop 0 beats memory, owner's own snoop bit ignored
    req_p = 8'h04;
    push("t3_grant2", 8'h04, 8'h00, 0, 3'd2, 1, 0, 1);
    tick(1);
    req_s = 8'h05; mem_req = 1'b1;
    push("t3_snoop0", 8'h04, 8'h01, 0, 3'd2, 1, 0, 1);
    tick(2);
    req_s = 8'h04;
    push("t3_snoop_clr", 8'h04, 8'h00, 0, 3'd2, 1, 0, 1);
    push("t3_mem_gnt", 8'h04, 8'h00, 1, 3'd2, 1, 0, 2);
    tick(3);
    mem_req = 1'b0;
    push("t3_mem_clr", 8'h04, 8'h00, 0, 3'd2, 1, 0, 1);
    tick(1);
    req_p = 8'h00; req_s = 8'h00;
    push("t3_release", 8'h00, 8'h00, 0, 3'd0, 0, 0, 1);
    tick(3);

    // 4: release in the same cycle snoop 4 rises; no snoop grant anywhere after
    req_p = 8'h08;
    push("t4_grant3", 8'h08, 8'h00, 0, 3'd3, 1, 0, 1);
    tick(2);
    req_p = 8'h00; req_s = 8'h10;
    push("t4_release", 8'h00, 8'h00, 0, 3'd0, 0, 0, 1);
    tick(5);
    req_s = 8'h00;
    tick(2);

    // 5: long hold by owner 3, single timeout pulse, grant retained
    req_p = 8'h08;
    push("t5_grant3", 8'h08, 8'h00, 0, 3'd3, 1, 0, 1);
    push("t5_timeout_on", 8'h08, 8'h00, 0, 3'd3, 1, 1, 1024);
    push("t5_timeout_off", 8'h08, 8'h00, 0, 3'd3, 1, 0, 1025);
    tick(1030);
    req_p = 8'h00;
    push("t5_release", 8'h00, 8'h00, 0, 3'd0, 0, 0, 1);
    tick(3);

    // 6: async reset during a snoop grant, then index 0 wins first
    req_p = 8'h20;
    push("t6_grant5", 8'h20, 8'h00, 0, 3'd5, 1, 0, 1);
    tick(1);
    req_s = 8'h01;
    push("t6_snoop0", 8'h20, 8'h01, 0, 3'd5, 1, 0, 1);
    tick(2);
    push("t6_reset_drop", 8'h00, 8'h00, 0, 3'd0, 0, 0, 1);
    #2 rst = 1'b1;
    #1 check("t6_async_drop", {13'h0, gnt_p, gnt_s, mem_gnt, busy, tmo}, 32'h0);
    req_p = 8'h00; req_s = 8'h00;
    tick(2);
    rst = 1'b0;
    tick(1);
    req_p = 8'hFF;
    push("t6_grant0_first", 8'h01, 8'h00, 0, 3'd0, 1, 0, 1);
    tick(3);
    req_p = 8'h00;
    push("t6_release", 8'h00, 8'h00, 0, 3'd0, 0, 0, 1);
    tick(4);

    check("events_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
